// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples a 7-segment bus, waits for a stable pattern, decodes it to a hex nibble
// Ports: clk, rst_n (async active-low), ena; seg_in[6:0] (bit0=a .. bit6=g);
//   digit_out[3:0], digit_valid (1-cycle new-digit strobe), blank, invalid, locked,
//   change_count[CNT_W-1:0] (saturating strobe count), history_out[15:0].
// Optional: define SEG7_CAP_HISTORY_EN to build the 4-deep accepted-digit history.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             blank,
  output logic             invalid,
  output logic             locked,
  output logic [CNT_W-1:0] change_count,
  output logic [15:0]      history_out
);
  typedef enum logic {TRACK, LOCKED} state_t;
  state_t state;
  logic [6:0] s1, s2, prev;
  logic [7:0] cnt;
  logic have_digit, match, done, hit, new_digit;
  logic [3:0] val;
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (s2)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: hit = 1'b0;
    endcase
  end
  assign match = s2 == prev;
  // a mismatch on the completing edge wins, so done requires match
  assign done = ena && state == TRACK && match && cnt == 8'(STABLE_CYCLES - 1);
  // the repeat compare is against the last table digit; blank/invalid leave digit_out untouched
  assign new_digit = done && hit && (!have_digit || val != digit_out);
  assign locked = state == LOCKED;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      state <= TRACK;
      cnt <= '0;
      digit_out <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b0;
      invalid <= 1'b0;
      have_digit <= 1'b0;
      change_count <= '0;
    end else begin
      s1 <= ACTIVE_LOW != 0 ? ~seg_in : seg_in;
      s2 <= s1;
      prev <= s2;
      digit_valid <= new_digit;
      if (!ena || !match) begin
        state <= TRACK;
        cnt <= '0;
      end else if (state == TRACK) begin
        if (done) state <= LOCKED;
        else cnt <= cnt + 8'd1;
      end
      if (done && hit) begin
        digit_out <= val;
        blank <= 1'b0;
        invalid <= 1'b0;
        have_digit <= 1'b1;
      end else if (done) begin
        blank <= s2 == 7'h00;
        invalid <= s2 != 7'h00;
      end
      if (new_digit && change_count != '1) change_count <= change_count + 1'b1;
    end
  end
`ifdef SEG7_CAP_HISTORY_EN
  logic [15:0] hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else if (new_digit) hist <= {hist[11:0], val};
  end
  assign history_out = hist;
`else
  assign history_out = 16'h0000;
`endif
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: random stimulus against a look-back reference model
module tb_seg7_capture_decoder;
  localparam int STABLE = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [6:0] seg_in = 7'h06;
  logic [3:0] digit_out, digit_out2;
  logic digit_valid, blank, invalid, locked, digit_valid2, blank2, invalid2, locked2;
  logic [7:0] change_count;
  logic [1:0] change_count2;
  logic [15:0] history_out, history_out2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
    .digit_out(digit_out), .digit_valid(digit_valid), .blank(blank), .invalid(invalid),
    .locked(locked), .change_count(change_count), .history_out(history_out));

  seg7_capture_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(2), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(~seg_in),
    .digit_out(digit_out2), .digit_valid(digit_valid2), .blank(blank2), .invalid(invalid2),
    .locked(locked2), .change_count(change_count2), .history_out(history_out2));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] samp [$];
  bit en_h [$];
  int nstrobe;
  bit seen, e_valid, e_blank, e_inv, e_locked;
  logic [3:0] e_digit;
  logic [15:0] e_hist;

  function automatic logic [6:0] sv(int i);
    return i < 0 ? 7'h00 : samp[i];
  endfunction

  task automatic model_reset();
    samp.delete();
    en_h.delete();
    nstrobe = 0;
    seen = 0; e_valid = 0; e_blank = 0; e_inv = 0; e_locked = 0;
    e_digit = 0; e_hist = 0;
  endtask

  // Pattern p is accepted on the edge where the run of enabled edges whose
  // synchronized sample equalled its predecessor reaches exactly STABLE.
  task automatic model_edge();
    int k, run, idx;
    logic [6:0] p;
    samp.push_back(seg_in);
    en_h.push_back(ena);
    k = samp.size() - 1;
    run = 0;
    for (int j = k; j >= 0 && run <= STABLE; j--) begin
      if (en_h[j] && sv(j - 2) == sv(j - 3)) run++;
      else break;
    end
    e_valid = 0;
    e_locked = run >= STABLE;
    if (run == STABLE) begin
      p = sv(k - 2);
      idx = -1;
      for (int i = 0; i < 16; i++) if (tbl[i] == p) idx = i;
      if (idx >= 0) begin
        e_valid = !seen || 4'(idx) != e_digit;
        e_digit = 4'(idx);
        seen = 1; e_blank = 0; e_inv = 0;
        if (e_valid) begin
          nstrobe++;
          e_hist = {e_hist[11:0], 4'(idx)};
        end
      end else begin
        e_blank = p == 7'h00;
        e_inv = p != 7'h00;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"}, 16'(digit_out), 0);
    check({tag, "_valid"}, 16'(digit_valid), 0);
    check({tag, "_blank"}, 16'(blank), 0);
    check({tag, "_invalid"}, 16'(invalid), 0);
    check({tag, "_locked"}, 16'(locked), 0);
    check({tag, "_count"}, 16'(change_count), 0);
    check({tag, "_hist"}, history_out, 0);
    check({tag, "_count2"}, 16'(change_count2), 0);
  endtask

  task automatic check_all();
    check("digit", 16'(digit_out), 16'(e_digit));
    check("valid", 16'(digit_valid), 16'(e_valid));
    check("blank", 16'(blank), 16'(e_blank));
    check("invalid", 16'(invalid), 16'(e_inv));
    check("locked", 16'(locked), 16'(e_locked));
    check("count", 16'(change_count), 16'(nstrobe > 255 ? 255 : nstrobe));
`ifdef SEG7_CAP_HISTORY_EN
    check("hist", history_out, e_hist);
`else
    check("hist", history_out, 16'h0000);
`endif
    check("digit2", 16'(digit_out2), 16'(e_digit));
    check("valid2", 16'(digit_valid2), 16'(e_valid));
    check("blank2", 16'(blank2), 16'(e_blank));
    check("invalid2", 16'(invalid2), 16'(e_inv));
    check("locked2", 16'(locked2), 16'(e_locked));
    check("count2", 16'(change_count2), 16'(nstrobe > 3 ? 3 : nstrobe));
  endtask

  initial begin
    int hold, ena_hold, r;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    hold = 20;
    ena_hold = 40;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      if (cyc == 2000) begin
        seg_in = 7'h06;
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold = 20;
        ena_hold = 40;
        ena = 1'b1;
        continue;
      end
      if (--hold <= 0) begin
        r = $urandom_range(0, 9);
        seg_in = r < 7 ? tbl[$urandom_range(0, 15)] : r == 7 ? 7'h00 : r == 8 ? 7'h49 : 7'($urandom);
        hold = $urandom_range(1, 12);
      end
      if (--ena_hold <= 0) begin
        ena = $urandom_range(0, 7) != 0;
        ena_hold = $urandom_range(3, 25);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receive-side counterpart to the 7-segment drive on uo_out[6:0].
- Samples a segment bus from the outside world, waits until the pattern has been stable, then decodes it back to a hex nibble.
- Reports each newly settled digit with a one-cycle strobe and keeps a saturating count of digit changes.
- Used in on-chip loopback and self-check of segment drivers.

Parameters:
- STABLE_CYCLES, 4: consecutive matching samples required before a pattern is accepted (legal range 1..255).
- CNT_W, 8: width of change_count.
- ACTIVE_LOW, 0: 1 = segment bits are active-low and are inverted before the compare/decode logic.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- ena, input, 1: block enable.
- seg_in, input, 7: segment bus; bit0=a through bit6=g.
- digit_out, output, 4: last accepted hex value.
- digit_valid, output, 1: one-cycle strobe when a new digit is accepted.
- blank, output, 1: level; last accepted pattern was all-off.
- invalid, output, 1: level; last accepted pattern was not in the decode table.
- locked, output, 1: level; the current pattern has been accepted.
- change_count, output, CNT_W: saturating count of digit_valid strobes.
- history_out, output, 16: digit history (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; FSM in TRACK; synchronizer and prev registers 0; match counter 0.
- Reset mid-operation: immediate clear to the reset values above, regardless of state.

Input path:
- Two-flop synchronizer: s1 <= seg_in, then s2 <= s1.
- prev <= s2 every cycle.
- match = (s2 == prev), evaluated after the ACTIVE_LOW inversion.

FSM states: TRACK, LOCKED.
- TRACK: on !match, cnt <= 0. On match, cnt increments.
- TRACK -> LOCKED: on the edge where match is true and cnt == STABLE_CYCLES-1. On that edge the capture happens and locked <= 1.
- LOCKED -> TRACK: on any !match. locked <= 0 and cnt <= 0. digit_out, blank and invalid hold their values.

Capture:
- Decode table: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F.
- Pattern in table: digit_out <= value, blank <= 0, invalid <= 0.
- Pattern 0x00: blank <= 1, invalid <= 0, digit_out holds.
- Any other pattern: invalid <= 1, blank <= 0, digit_out holds.
- digit_valid pulses for 1 cycle only when a table pattern is accepted and its value differs from the previously accepted value, or it is the first acceptance after reset.
- change_count increments on each digit_valid and saturates at all-ones; it never wraps.

Latency:
- A pattern first sampled by s1 on edge 0 produces digit_valid (and locked) high after edge STABLE_CYCLES+2.
- A glitch of fewer than STABLE_CYCLES+1 cycles is never accepted.

Same digit reappearing:
- Sequence 5 -> blank -> 5: no second strobe. The previous-value compare uses the last table digit, and blank/invalid acceptances do not reset it.

ena = 0:
- Synchronizer and prev keep running.
- cnt is forced to 0, FSM is forced to TRACK, locked = 0.
- digit_valid is suppressed; digit_out, blank, invalid, change_count and history hold.
- After ena rises, a full stability window is required before the next acceptance.

Simultaneous events:
- A mismatch on the edge that would have completed the window takes priority: no capture, cnt <= 0.

Optional Feature:
- Macro: SEG7_CAP_HISTORY_EN.
- Defined: history_out is a 4-entry shift register of accepted digits, newest in [3:0] and oldest in [15:12].
  - Shifts on each digit_valid, in the same cycle.
  - Reset value 0x0000; holds while ena = 0.
- Not defined: no history register is built and history_out is constantly 16'h0000.

Test Plan:
- Reset: rst_n=0 asynchronously, mid-stream with seg_in=0x06 → all outputs 0 immediately. Release with seg_in=0x06 held and STABLE_CYCLES=4 → digit_valid high for exactly 1 cycle after edge 6, digit_out=1, change_count=1, locked=1.
- Sequence: seg_in 0x3F, then 0x4F, then 0x71, each held 10 cycles → three strobes with digit_out 0, 3, F; change_count=3; history_out=0x003F (feature on) or 0x0000 (feature off).
- Glitch rejection: with 0x5B locked, drive 0x7F for 4 cycles and return to 0x5B → no strobe, digit_out stays 2, locked drops and then re-asserts.
- Blank/invalid: hold 0x00 → blank=1, no strobe, digit_out holds. Hold 0x49 → invalid=1, blank=0. Return to the previous digit → no strobe.
- ena gating: deassert ena while 0x66 is settling, hold 20 cycles → no strobe, locked=0. Reassert ena → strobe exactly STABLE_CYCLES edges after ena rises (synchronizer already full), digit_out=4.
- Saturation: CNT_W=2 with 5 distinct digits → change_count goes 1, 2, 3, 3, 3. With ACTIVE_LOW=1, seg_in=~0x6D → digit_out=5.
